// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 selector family: default width and select encoding.
package mux_pkg;

  localparam int MUX_DEFAULT_WIDTH = 1;
  localparam int MUX_MIN_WIDTH     = 1;
  localparam int MUX_MAX_WIDTH     = 64;

  // Select encoding shared by the RTL and its bench.
  typedef enum logic {
    SEL_D0 = 1'b0,
    SEL_D1 = 1'b1
  } sel_e;

endpackage : mux_pkg

// File: rtl/mux_2_comb.sv
// Pure combinational WIDTH-bit 2:1 select with one select for the whole word.
module mux_2_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // The conditional operator is used deliberately: with an unknown select
  // it merges the two words bitwise, so bits where d0 and d1 agree keep
  // their value and only differing bits go X in simulation.
  assign y = (sel == SEL_D1) ? d1 : d0;

endmodule : mux_2_comb

// File: rtl/mux_2.sv
// Two-input selector with a flopped output and a combinational bypass copy.
module mux_2
  import mux_pkg::*;
#(
  parameter int               WIDTH     = MUX_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_comb
);

  // Reject unsupported widths at elaboration rather than building a bad netlist.
  if (WIDTH < MUX_MIN_WIDTH || WIDTH > MUX_MAX_WIDTH) begin : g_bad_width
    $error("mux_2: WIDTH=%0d outside legal range %0d..%0d",
           WIDTH, MUX_MIN_WIDTH, MUX_MAX_WIDTH);
  end

  logic [WIDTH-1:0] sel_data;

  mux_2_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .d0  (d0),
    .d1  (d1),
    .sel (sel),
    .y   (sel_data)
  );

  // The bypass path is the unregistered select; it has no reset value.
  assign z_comb = sel_data;

  // Output register: loads the selected word every cycle, forced to RESET_VAL
  // the moment rst_n falls.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values, regardless of how many always_ff blocks share the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z <= RESET_VAL;
    end else begin
      z <= sel_data;
    end
  end

endmodule : mux_2

// File: tb/tb_mux_2.sv
// Self-checking bench for mux_2: directed scenarios plus randomized traffic
// compared against a table-lookup reference model.
module tb_mux_2;
  import mux_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  // Narrow instance (WIDTH=1, default reset value).
  logic n_d0, n_d1, n_sel, n_z, n_zc;
  // Wide instance (WIDTH=8, RESET_VAL=8'hA5).
  logic [7:0] w_d0, w_d1, w_z, w_zc;
  logic       w_sel;

  int errors = 0;
  int checks = 0;

  mux_2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) dut_n (
    .clk    (clk),
    .rst_n  (rst_n),
    .d0     (n_d0),
    .d1     (n_d1),
    .sel    (n_sel),
    .z      (n_z),
    .z_comb (n_zc)
  );

  mux_2 #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5)
  ) dut_w (
    .clk    (clk),
    .rst_n  (rst_n),
    .d0     (w_d0),
    .d1     (w_d1),
    .sel    (w_sel),
    .z      (w_z),
    .z_comb (w_zc)
  );

  always #5 clk = ~clk;

  // Reference select: pick an entry from a two-element table by the select bit.
  function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b,
                                      input logic s);
    logic [7:0] opts [2];
    opts[0] = a;
    opts[1] = b;
    return opts[s];
  endfunction

  task automatic test_reset();
    n_d0 = 1'b0; n_d1 = 1'b1; n_sel = SEL_D1;
    w_d0 = 8'h11; w_d1 = 8'h22; w_sel = SEL_D0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (n_z !== 1'b0) begin
      errors++; $display("FAIL reset_n_z: got %b expected %b", n_z, 1'b0);
    end
    checks++;
    if (w_z !== 8'hA5) begin
      errors++; $display("FAIL reset_w_z: got %h expected %h", w_z, 8'hA5);
    end
    checks++;
    if (n_zc !== 1'b1) begin
      errors++; $display("FAIL reset_n_zcomb: got %b expected %b", n_zc, 1'b1);
    end
    checks++;
    if (w_zc !== 8'h11) begin
      errors++; $display("FAIL reset_w_zcomb: got %h expected %h", w_zc, 8'h11);
    end
    // A clock edge while held in reset must not load anything.
    @(posedge clk); #1;
    checks++;
    if (n_z !== 1'b0 || w_z !== 8'hA5) begin
      errors++; $display("FAIL reset_hold: got n=%b w=%h expected n=0 w=a5", n_z, w_z);
    end
  endtask

  task automatic test_reset_release();
    @(negedge clk);
    n_d0 = 1'b0; n_d1 = 1'b1; n_sel = SEL_D1;
    w_d0 = 8'h5A; w_d1 = 8'h0F; w_sel = SEL_D1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (n_z !== 1'b0) begin
      errors++; $display("FAIL release_before_edge: got %b expected %b", n_z, 1'b0);
    end
    checks++;
    if (w_z !== 8'hA5) begin
      errors++; $display("FAIL release_w_before_edge: got %h expected %h", w_z, 8'hA5);
    end
    @(posedge clk); #1;
    checks++;
    if (n_z !== 1'b1) begin
      errors++; $display("FAIL release_after_edge: got %b expected %b", n_z, 1'b1);
    end
    checks++;
    if (w_z !== 8'h0F) begin
      errors++; $display("FAIL release_w_after_edge: got %h expected %h", w_z, 8'h0F);
    end
  endtask

  task automatic test_truth_table();
    logic [2:0] v;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      @(negedge clk);
      n_d0 = v[2]; n_d1 = v[1]; n_sel = v[0];
      exp = pick({7'b0, v[2]}, {7'b0, v[1]}, v[0]);
      #1;
      checks++;
      if (n_zc !== exp[0]) begin
        errors++; $display("FAIL tt_zcomb[%0d]: got %b expected %b", i, n_zc, exp[0]);
      end
      @(posedge clk); #1;
      checks++;
      if (n_z !== exp[0]) begin
        errors++; $display("FAIL tt_z[%0d]: got %b expected %b", i, n_z, exp[0]);
      end
    end
  endtask

  task automatic test_unselected_isolation();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_sel = SEL_D0; n_d0 = 1'b0; n_d1 = i[0];
      #1;
      checks++;
      if (n_zc !== 1'b0) begin
        errors++; $display("FAIL iso_zcomb[%0d]: got %b expected 0", i, n_zc);
      end
      @(posedge clk); #1;
      checks++;
      if (n_z !== 1'b0) begin
        errors++; $display("FAIL iso_z[%0d]: got %b expected 0", i, n_z);
      end
    end
  endtask

  task automatic test_wide_word();
    @(negedge clk);
    w_d0 = 8'h3C; w_d1 = 8'hC3; w_sel = SEL_D1;
    @(posedge clk); #1;
    checks++;
    if (w_z !== 8'hC3) begin
      errors++; $display("FAIL wide_sel1: got %h expected %h", w_z, 8'hC3);
    end
    @(negedge clk);
    w_sel = SEL_D0;
    #1;
    checks++;
    if (w_zc !== 8'h3C) begin
      errors++; $display("FAIL wide_sel0_comb: got %h expected %h", w_zc, 8'h3C);
    end
    checks++;
    if (w_z !== 8'hC3) begin
      errors++; $display("FAIL wide_latency: got %h expected %h", w_z, 8'hC3);
    end
    @(posedge clk); #1;
    checks++;
    if (w_z !== 8'h3C) begin
      errors++; $display("FAIL wide_sel0: got %h expected %h", w_z, 8'h3C);
    end
    // Equal inputs give that value for either select.
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      w_d0 = 8'h96; w_d1 = 8'h96; w_sel = s[0];
      #1;
      checks++;
      if (w_zc !== 8'h96) begin
        errors++; $display("FAIL wide_equal_comb[sel=%0d]: got %h expected 96", s, w_zc);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    n_d0 = 1'b1; n_sel = SEL_D0;
    w_d0 = 8'h77; w_sel = SEL_D0;
    @(posedge clk); #1;
    checks++;
    if (n_z !== 1'b1) begin
      errors++; $display("FAIL async_pre_z: got %b expected 1", n_z);
    end
    // Assert reset between edges.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (n_z !== 1'b0) begin
      errors++; $display("FAIL async_n_z: got %b expected 0", n_z);
    end
    checks++;
    if (w_z !== 8'hA5) begin
      errors++; $display("FAIL async_w_z: got %h expected a5", w_z);
    end
    n_d0 = 1'b0; n_d1 = 1'b1; n_sel = SEL_D1;
    #1;
    checks++;
    if (n_zc !== 1'b1) begin
      errors++; $display("FAIL async_zcomb_tracks: got %b expected 1", n_zc);
    end
    @(posedge clk); #1;
    checks++;
    if (n_z !== 1'b0) begin
      errors++; $display("FAIL async_hold: got %b expected 0", n_z);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_w, exp_n;
    logic [7:0] a, b;
    logic       s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      w_d0 = a; w_d1 = b; w_sel = s;
      exp_w = pick(a, b, s);
      n_d0 = a[0]; n_d1 = b[0]; n_sel = s;
      exp_n = pick({7'b0, a[0]}, {7'b0, b[0]}, s);
      #1;
      checks++;
      if (w_zc !== exp_w || n_zc !== exp_n[0]) begin
        errors++;
        $display("FAIL rand_comb[%0d]: got w=%h n=%b expected w=%h n=%b",
                 i, w_zc, n_zc, exp_w, exp_n[0]);
      end
      @(posedge clk); #1;
      checks++;
      if (w_z !== exp_w || n_z !== exp_n[0]) begin
        errors++;
        $display("FAIL rand_z[%0d]: got w=%h n=%b expected w=%h n=%b",
                 i, w_z, n_z, exp_w, exp_n[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_truth_table();
    test_unselected_isolation();
    test_wide_word();
    test_async_reset();
    test_reset_release();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_2

// File: doc/mux_2.md
# mux_2

Two-input selector with a registered output. Each rising clock edge, `z` takes `d1` when `sel` is 1 and `d0` when `sel` is 0. A combinational copy of the selected value is also provided for paths that cannot absorb the register latency. The block is a leaf primitive used wherever a single-level data select with a clean, flopped output is required.

## Interface
- `WIDTH`, default 1: bit width of `d0`, `d1`, `z`, `z_comb`; legal range 1..64.
- `RESET_VAL`, default 0 (all bits): value loaded into `z` while reset is asserted.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `d0`  in  WIDTH  data input, selected when `sel`=0.
- `d1`  in  WIDTH  data input, selected when `sel`=1.
- `sel`  in  1  select; 0 selects `d0`, 1 selects `d1`.
- `z`  out  WIDTH  registered selected data.
- `z_comb`  out  WIDTH  combinational selected data, not registered.

## Operation
- Selection function: `sel`=0 gives `d0`; `sel`=1 gives `d1`. It is applied bitwise across all WIDTH bits, with one `sel` for the whole word.
- `z_comb` equals the selection function of the current inputs at all times, including during reset.
- `z` loads the selection function on every rising `clk` edge while `rst_n`=1. There is no enable; `z` samples every cycle.
- Reset value: `z` = `RESET_VAL` immediately when `rst_n` falls, independent of `clk`. `z_comb` has no reset value.
- Unselected input: changes on the unselected input never affect `z` or `z_comb`.
- Equal inputs: when `d0`==`d1`, both outputs equal that value regardless of `sel`.
- Unknown `sel` in simulation:
  - bits where `d0` and `d1` agree output that value;
  - bits where they differ output X.
- No internal state exists other than the `z` register.

## Timing
- `z_comb` has zero-cycle latency and is purely combinational from `d0`, `d1` and `sel`.
- `z` has one-cycle latency. Inputs sampled at rising edge N appear on `z` after edge N and hold until edge N+1.
- Reset assert is asynchronous. `z` goes to `RESET_VAL` within the same delta, with no clock needed.
- Reset deassert: the first rising `clk` edge with `rst_n`=1 loads the selected data. `rst_n` must meet recovery/removal timing relative to `clk`; upstream reset synchronisation is the integrator's job.
- Reset asserted mid-operation: any pending capture is discarded and `z` holds `RESET_VAL` until after deassertion.
- `sel` and data changing in the same cycle: the values present at the edge are sampled, with no ordering dependency.

## Structure
- Shared package `mux_pkg`:
  - constant `MUX_DEFAULT_WIDTH` = 1;
  - a typedef `sel_e` naming SEL_D0=0 and SEL_D1=1, used by both RTL and bench.
- Sub-module `mux_2_comb` holds the pure combinational WIDTH-bit 2:1 select and drives `z_comb`.
- The top level adds the reset-capable output register and parameter checks. A WIDTH outside 1..64 is an elaboration error.

## Test plan
- Exhaustive truth table, WIDTH=1: step through all 8 combinations of (`d0`,`d1`,`sel`) from 000 to 111, one per cycle.
  - `z_comb` must equal `d0` for `sel`=0 and `d1` for `sel`=1 in every combination (e.g. d0=1, d1=0, sel=1 gives 0).
  - `z` must show the same value one cycle later.
- Async reset: with `z`=1, drive `rst_n` low between clock edges. `z` must be 0 at once; `z_comb` still tracks its inputs.
- Reset release: deassert `rst_n` with d1=1, sel=1.
  - `z` must stay 0 until the first rising edge after release.
  - `z` must be 1 after that edge.
- Unselected isolation: hold sel=0 and d0=0, toggle `d1` every cycle for 10 cycles. `z` and `z_comb` must stay 0 throughout.
- Wide word, WIDTH=8, RESET_VAL=8'hA5:
  - reset gives `z`=8'hA5;
  - d0=8'h3C, d1=8'hC3, sel=1 gives `z`=8'hC3 next cycle;
  - switching to sel=0 gives 8'h3C the cycle after.
